round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port `clock`, reset port `reset_n`.
REQ-002 Parameter MAX_HOLD, default 16, maximum consecutive cycles one requester SHALL hold the grant (legal range 2..255).
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port req  input  4  per-requester request, level; bit k = requester k.
REQ-006 Port grant  output  4  one-hot grant, all-zero when no owner.
REQ-007 Port owner  output  2  index of current owner; valid only while grant != 0.
REQ-008 Port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.
REQ-009 Port state  output  2  FSM state for waveform monitoring: IDLE=0, BUSY=1, GAP=2.
REQ-010 Port grant_total  output  8  count of grants issued, wraps 255->0.

Function
REQ-011 FSM SHALL have states IDLE, BUSY, GAP; encoding 3 is illegal and SHALL transition to IDLE on the next edge with all outputs in reset values.
REQ-012 Rotating pointer ptr (2 bits) SHALL select the winner: first asserted req bit searching ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-013 IDLE: if req != 0 at an edge, grant SHALL assert on that edge (visible the following cycle, 1-cycle latency), state->BUSY, hold counter=1, grant_total+=1.
REQ-014 IDLE with req == 0 SHALL remain IDLE with grant=0.
REQ-015 BUSY: grant SHALL remain stable and one-hot; hold counter increments each cycle the owner's req stays high.
REQ-016 BUSY: when req[owner] is sampled low, grant SHALL clear on that edge, ptr = owner+1 (3 wraps to 0), state->GAP.
REQ-017 BUSY: when hold counter == MAX_HOLD and req[owner] is still high, grant SHALL clear, timeout SHALL pulse for exactly one cycle, ptr = owner+1, state->GAP.
REQ-018 Simultaneous release and expiry on the same edge SHALL be treated as release: no timeout pulse.
REQ-019 GAP SHALL last exactly one cycle with grant=0 (bus turnaround), then: if req != 0, grant the winner per REQ-012 and go BUSY (as REQ-013); else go IDLE.
REQ-020 A requester revoked by timeout that keeps req high SHALL be re-granted only after every other asserting requester has been served once.
REQ-021 Changes to non-owner req bits during BUSY SHALL NOT affect grant or owner.
REQ-022 grant, owner, timeout, state SHALL be registered outputs; no combinational path from req to any output.
REQ-023 grant_total SHALL increment by exactly 1 per grant assertion and wrap from 255 to 0 without a flag.

Reset
REQ-024 reset_n low SHALL immediately (asynchronously) force state=IDLE, grant=0, owner=0, timeout=0, ptr=0, hold counter=0, grant_total=0.
REQ-025 Reset asserted mid-BUSY SHALL drop grant without passing through GAP and without a timeout pulse.
REQ-026 After reset_n rises, the first edge SHALL be evaluated as IDLE with ptr=0.

Verification
REQ-027 req=4'b0001 held 3 cycles then dropped -> grant=0001 one cycle after req, held 3 cycles, one GAP cycle, state IDLE, grant_total=1.
REQ-028 req=4'b1111 each requester releasing after 2 cycles -> grant order 0001,0010,0100,1000,0001 with one zero cycle between each.
REQ-029 req=4'b0011 with MAX_HOLD=4, never released -> grant=0001 for 4 cycles, timeout pulse, GAP, grant=0010 for 4 cycles, timeout, then 0001.
REQ-030 Owner 3 releases with req=4'b1001 -> ptr wraps to 0, next grant=0001.
REQ-031 reset_n pulsed low for 1 cycle while grant=0100 -> grant=0 immediately, timeout=0, grant_total=0; with req=4'b0100 held, grant=0100 one edge after reset_n rises.
REQ-032 Release coincident with MAX_HOLD expiry -> timeout stays 0, GAP entered, ptr advanced.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with a hold limit per grant,
// a one-cycle turnaround gap after every grant and a running grant count.
module round_robin_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       timeout,
  output logic [1:0] state,
  output logic [7:0] grant_total
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_CNT = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic       timeout_q, timeout_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] total_q, total_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Search requesters starting at the rotating pointer; the first asserted one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; a release always beats a hold-limit expiry.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    total_d   = total_q;
    case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          grant_d = 4'b0001 << win_idx;
          owner_d = win_idx;
          hold_d  = 8'd1;
          total_d = total_q + 8'd1;
          state_d = BUSY;
        end else begin
          grant_d = 4'b0000;
          hold_d  = 8'd0;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!req[owner_q]) begin
          grant_d = 4'b0000;
          ptr_d   = owner_q + 2'd1;
          hold_d  = 8'd0;
          state_d = GAP;
        end else if (hold_q == MAX_HOLD_CNT) begin
          grant_d   = 4'b0000;
          ptr_d     = owner_q + 2'd1;
          hold_d    = 8'd0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        grant_d = 4'b0000;
        owner_d = 2'd0;
        ptr_d   = 2'd0;
        hold_d  = 8'd0;
        total_d = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  // All state and every output is registered; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      owner_q   <= 2'd0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      total_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      total_q   <= total_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign timeout     = timeout_q;
  assign state       = state_q;
  assign grant_total = total_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed self-checking bench for the round-robin arbiter (hold limit 4).
module tb_round_robin_arbiter;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       timeout;
  logic [1:0] state;
  logic [7:0] grant_total;

  int checkCount;
  int failCount;

  round_robin_arbiter #(.MAX_HOLD(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .grant       (grant),
    .owner       (owner),
    .timeout     (timeout),
    .state       (state),
    .grant_total (grant_total)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    req     = 4'b0000;
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [3:0] nextReq [4];

  // Directed scenarios with hand-computed expectations.
  initial begin
    checkCount = 0;
    failCount  = 0;
    nextReq[0] = 4'b1110;
    nextReq[1] = 4'b1100;
    nextReq[2] = 4'b1000;
    nextReq[3] = 4'b0001;
    req     = 4'b0000;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_timeout", 32'(timeout), 32'h0);
    checkOutput("rst_state", 32'(state), 32'h0);
    checkOutput("rst_total", 32'(grant_total), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single requester holds for three cycles then releases.
    applyStimulus(4'b0001);
    stepClock();
    checkOutput("s1_grant0", 32'(grant), 32'h1);
    checkOutput("s1_state0", 32'(state), 32'h1);
    checkOutput("s1_total0", 32'(grant_total), 32'h1);
    stepClock();
    checkOutput("s1_grant1", 32'(grant), 32'h1);
    stepClock();
    checkOutput("s1_grant2", 32'(grant), 32'h1);
    applyStimulus(4'b0000);
    stepClock();
    checkOutput("s1_gap_grant", 32'(grant), 32'h0);
    checkOutput("s1_gap_state", 32'(state), 32'h2);
    checkOutput("s1_gap_timeout", 32'(timeout), 32'h0);
    stepClock();
    checkOutput("s1_idle_state", 32'(state), 32'h0);
    checkOutput("s1_idle_total", 32'(grant_total), 32'h1);

    // All four requesting, each releasing after two cycles.
    doReset();
    applyStimulus(4'b1111);
    for (int k = 0; k < 4; k++) begin
      stepClock();
      checkOutput($sformatf("rr_grant%0d_a", k), 32'(grant), 32'(1 << k));
      checkOutput($sformatf("rr_owner%0d", k), 32'(owner), 32'(k));
      stepClock();
      checkOutput($sformatf("rr_grant%0d_b", k), 32'(grant), 32'(1 << k));
      applyStimulus(nextReq[k]);
      stepClock();
      checkOutput($sformatf("rr_gap%0d", k), 32'(grant), 32'h0);
    end
    stepClock();
    checkOutput("rr_wrap_grant", 32'(grant), 32'h1);
    checkOutput("rr_total", 32'(grant_total), 32'h5);
    applyStimulus(4'b0000);
    stepClock();
    stepClock();
    checkOutput("rr_idle", 32'(state), 32'h0);

    // Owner 3 releases; pointer must wrap to requester 0; other req changes ignored.
    applyStimulus(4'b1000);
    stepClock();
    checkOutput("w_grant3", 32'(grant), 32'h8);
    applyStimulus(4'b1001);
    stepClock();
    checkOutput("w_nonowner_grant", 32'(grant), 32'h8);
    checkOutput("w_nonowner_owner", 32'(owner), 32'h3);
    applyStimulus(4'b0111);
    stepClock();
    checkOutput("w_gap", 32'(grant), 32'h0);
    stepClock();
    checkOutput("w_next_grant", 32'(grant), 32'h1);
    applyStimulus(4'b0000);
    stepClock();
    stepClock();

    // Two requesters never releasing; hold limit forces rotation.
    doReset();
    applyStimulus(4'b0011);
    for (int c = 0; c < 4; c++) begin
      stepClock();
      checkOutput($sformatf("to_a_grant%0d", c), 32'(grant), 32'h1);
      checkOutput($sformatf("to_a_timeout%0d", c), 32'(timeout), 32'h0);
    end
    stepClock();
    checkOutput("to_a_revoke_grant", 32'(grant), 32'h0);
    checkOutput("to_a_pulse", 32'(timeout), 32'h1);
    checkOutput("to_a_state", 32'(state), 32'h2);
    for (int c = 0; c < 4; c++) begin
      stepClock();
      checkOutput($sformatf("to_b_grant%0d", c), 32'(grant), 32'h2);
      checkOutput($sformatf("to_b_timeout%0d", c), 32'(timeout), 32'h0);
    end
    stepClock();
    checkOutput("to_b_revoke_grant", 32'(grant), 32'h0);
    checkOutput("to_b_pulse", 32'(timeout), 32'h1);
    stepClock();
    checkOutput("to_c_grant", 32'(grant), 32'h1);
    checkOutput("to_c_timeout", 32'(timeout), 32'h0);
    applyStimulus(4'b0000);
    stepClock();
    checkOutput("to_release_timeout", 32'(timeout), 32'h0);
    stepClock();

    // Release on the same edge the hold limit is reached counts as a release.
    applyStimulus(4'b0010);
    for (int c = 0; c < 4; c++) begin
      stepClock();
      checkOutput($sformatf("co_grant%0d", c), 32'(grant), 32'h2);
    end
    applyStimulus(4'b1001);
    stepClock();
    checkOutput("co_grant_clear", 32'(grant), 32'h0);
    checkOutput("co_no_timeout", 32'(timeout), 32'h0);
    checkOutput("co_state_gap", 32'(state), 32'h2);
    applyStimulus(4'b1111);
    stepClock();
    checkOutput("co_ptr_advanced", 32'(grant), 32'h4);
    applyStimulus(4'b0000);
    stepClock();
    stepClock();

    // Reset pulsed while requester 2 owns the grant.
    applyStimulus(4'b0100);
    stepClock();
    checkOutput("mr_grant", 32'(grant), 32'h4);
    checkOutput("mr_total_pre", 32'(grant_total), 32'h6);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mr_async_grant", 32'(grant), 32'h0);
    checkOutput("mr_async_timeout", 32'(timeout), 32'h0);
    checkOutput("mr_async_total", 32'(grant_total), 32'h0);
    checkOutput("mr_async_state", 32'(state), 32'h0);
    #10;
    checkOutput("mr_held_grant", 32'(grant), 32'h0);
    reset_n = 1'b1;
    stepClock();
    checkOutput("mr_regrant", 32'(grant), 32'h4);
    checkOutput("mr_total_post", 32'(grant_total), 32'h1);
    applyStimulus(4'b0000);
    stepClock();
    stepClock();

    // Grant counter wraps from 255 to 0 under continuous timeouts.
    applyStimulus(4'b1111);
    stepClock();
    checkOutput("gt_start", 32'(grant_total), 32'h2);
    repeat (5 * 253) stepClock();
    checkOutput("gt_255", 32'(grant_total), 32'hFF);
    repeat (5) stepClock();
    checkOutput("gt_wrap", 32'(grant_total), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
